// File: rtl/branch_predictor_bht.sv
// PC-indexed table of saturating counters with branch/mispredict statistics.
// Optional gshare indexing (global history XORed into the index) under BHT_GSHARE_EN.
module branch_predictor_bht #(
    parameter  int unsigned ENTRIES  = 16,
    parameter  int unsigned CTR_W    = 2,
    parameter  int unsigned INIT_CTR = 1,
    parameter  int unsigned PC_W     = 32,
    parameter  int unsigned STAT_W   = 32,
    localparam int unsigned IDX_W    = $clog2(ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PC_W-1:0]   lookup_pc_i,
    output logic              predict_o,
    output logic [IDX_W-1:0]  lookup_idx_o,
    input  logic              update_i,
    input  logic [IDX_W-1:0]  update_idx_i,
    input  logic              update_pred_i,
    input  logic              result_i,
    output logic [STAT_W-1:0] stat_branches_o,
    output logic [STAT_W-1:0] stat_mispred_o
);

    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_RST  = CTR_W'(INIT_CTR);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [CTR_W-1:0]  ctr_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_d [ENTRIES];
    logic [STAT_W-1:0] branches_q, branches_d;
    logic [STAT_W-1:0] mispred_q, mispred_d;
    logic [IDX_W-1:0]  lookup_idx;

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0]  ghr_q, ghr_d;
`endif

    // Only PC bits [IDX_W+1:2] select an entry; the rest are intentionally ignored.
    logic unused_pc;
    assign unused_pc = ^lookup_pc_i;

    // Lookup: index and prediction straight from registered table state (no bypass).
    always_comb begin
`ifdef BHT_GSHARE_EN
        lookup_idx = lookup_pc_i[IDX_W+1:2] ^ ghr_q;
`else
        lookup_idx = lookup_pc_i[IDX_W+1:2];
`endif
        lookup_idx_o = lookup_idx;
        predict_o    = ctr_q[lookup_idx][CTR_W-1];
    end

    // Next state: saturating counter update plus saturating statistics.
    always_comb begin
        ctr_d      = ctr_q;
        branches_d = branches_q;
        mispred_d  = mispred_q;
`ifdef BHT_GSHARE_EN
        ghr_d      = ghr_q;
`endif
        if (update_i) begin
            if (result_i) begin
                if (ctr_q[update_idx_i] != CTR_MAX) begin
                    ctr_d[update_idx_i] = ctr_q[update_idx_i] + CTR_W'(1);
                end
            end else begin
                if (ctr_q[update_idx_i] != '0) begin
                    ctr_d[update_idx_i] = ctr_q[update_idx_i] - CTR_W'(1);
                end
            end
            if (branches_q != STAT_MAX) begin
                branches_d = branches_q + STAT_W'(1);
            end
            if ((update_pred_i != result_i) && (mispred_q != STAT_MAX)) begin
                mispred_d = mispred_q + STAT_W'(1);
            end
`ifdef BHT_GSHARE_EN
            // Truncating {ghr, result} to IDX_W bits shifts left, newest outcome in bit 0.
            ghr_d = IDX_W'({ghr_q, result_i});
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CTR_RST;
            end
            branches_q <= '0;
            mispred_q  <= '0;
`ifdef BHT_GSHARE_EN
            ghr_q      <= '0;
`endif
        end else begin
            ctr_q      <= ctr_d;
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
`ifdef BHT_GSHARE_EN
            ghr_q      <= ghr_d;
`endif
        end
    end

    assign stat_branches_o = branches_q;
    assign stat_mispred_o  = mispred_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed vector table, async reset
// sequence, and randomized traffic against a behavioural table model.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        upd = 1'b0;
    logic [3:0]  uidx = '0;
    logic        upred = 1'b0;
    logic        res = 1'b0;

    logic        pred, pred_s;
    logic [3:0]  lidx, lidx_s;
    logic [31:0] br, mp;
    logic [1:0]  br_s, mp_s;

    int checks = 0;
    int errors = 0;

    branch_predictor_bht dut (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(pc), .predict_o(pred),
        .lookup_idx_o(lidx), .update_i(upd), .update_idx_i(uidx),
        .update_pred_i(upred), .result_i(res),
        .stat_branches_o(br), .stat_mispred_o(mp)
    );

    // Narrow statistics copy to exercise saturation at all-ones.
    branch_predictor_bht #(.STAT_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(pc), .predict_o(pred_s),
        .lookup_idx_o(lidx_s), .update_i(upd), .update_idx_i(uidx),
        .update_pred_i(upred), .result_i(res),
        .stat_branches_o(br_s), .stat_mispred_o(mp_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat3(input longint v);
        return (v > 3) ? 32'd3 : 32'(v);
    endfunction

    // Behavioural model: plain integer counters clamped to [0,3], history as an int.
    int     ctr_m [16];
    longint br_m, mp_m;
    int     ghr_m;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ctr_m[i] = 1;
        br_m = 0; mp_m = 0; ghr_m = 0;
    endtask

    function automatic int model_idx(input logic [31:0] p);
        int b;
        b = int'((p / 4) % 16);
`ifdef BHT_GSHARE_EN
        return b ^ ghr_m;
`else
        return b;
`endif
    endfunction

    task automatic model_update(input logic u, input logic [3:0] i, input logic pr, input logic r);
        if (u) begin
            br_m++;
            if (pr != r) mp_m++;
            if (r) ctr_m[i] = (ctr_m[i] + 1 > 3) ? 3 : ctr_m[i] + 1;
            else   ctr_m[i] = (ctr_m[i] - 1 < 0) ? 0 : ctr_m[i] - 1;
            ghr_m = (ghr_m * 2 + int'(r)) % 16;
        end
    endtask

    task automatic drive(input logic [31:0] p, input logic u, input logic [3:0] i,
                         input logic pr, input logic r);
        pc = p; upd = u; uidx = i; upred = pr; res = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        upd;
        logic [3:0]  uidx;
        logic        upred;
        logic        res;
        logic [3:0]  e_idx;
        logic        e_pred;   // before the edge
        int          e_br;     // after the edge
        int          e_mp;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{32'h0000_0054, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b0, 0,  0};
        vecs[1]  = '{32'h0000_0054, 1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 1'b0, 1,  1};
        vecs[2]  = '{32'h0000_0054, 1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 1'b1, 2,  2};
        vecs[3]  = '{32'h0000_0054, 1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 1'b1, 3,  3};
        vecs[4]  = '{32'h0000_0054, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 4,  3};
        vecs[5]  = '{32'h0000_0054, 1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 5,  4};
        vecs[6]  = '{32'h0000_0054, 1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 6,  5};
        vecs[7]  = '{32'h0000_0054, 1'b0, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 6,  5};
        vecs[8]  = '{32'h0000_0054, 1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 1'b0, 7,  6};
        vecs[9]  = '{32'h0000_0058, 1'b0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b0, 7,  6};
        vecs[10] = '{32'hFFFF_FF57, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 7,  6};
        vecs[11] = '{32'h0000_0058, 1'b1, 4'd6, 1'b0, 1'b0, 4'd6, 1'b0, 8,  6};
        vecs[12] = '{32'h0000_0058, 1'b1, 4'd6, 1'b0, 1'b0, 4'd6, 1'b0, 9,  6};
        vecs[13] = '{32'h0000_0058, 1'b1, 4'd6, 1'b0, 1'b1, 4'd6, 1'b0, 10, 7};
        vecs[14] = '{32'h0000_0058, 1'b0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b0, 10, 7};

        do_reset();

        // Reset state.
        #1;
        check("reset_br", br, 32'd0);
        check("reset_mp", mp, 32'd0);
        check("reset_br_s", 32'(br_s), 32'd0);

`ifndef BHT_GSHARE_EN
        // Directed table: training, saturation both ends, stats, same-cycle update.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(vecs[k].pc, vecs[k].upd, vecs[k].uidx, vecs[k].upred, vecs[k].res);
            #1;
            check($sformatf("vec%0d_idx", k), 32'(lidx), 32'(vecs[k].e_idx));
            check($sformatf("vec%0d_pred", k), 32'(pred), 32'(vecs[k].e_pred));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_br", k), br, 32'(vecs[k].e_br));
            check($sformatf("vec%0d_mp", k), mp, 32'(vecs[k].e_mp));
            check($sformatf("vec%0d_br_s", k), 32'(br_s), sat3(longint'(vecs[k].e_br)));
            check($sformatf("vec%0d_mp_s", k), 32'(mp_s), sat3(longint'(vecs[k].e_mp)));
        end

        // Train idx 5 to 3, then assert reset between edges with an update pending.
        @(negedge clk);
        drive(32'h54, 1'b1, 4'd5, 1'b1, 1'b1);
        @(negedge clk);
        drive(32'h54, 1'b0, 4'd5, 1'b1, 1'b1);
        #1;
        check("pre_rst_pred", 32'(pred), 32'd1);
        drive(32'h54, 1'b1, 4'd5, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_pred", 32'(pred), 32'd0);
        check("async_rst_br", br, 32'd0);
        check("async_rst_mp", mp, 32'd0);
        @(posedge clk);
        #1;
        check("rst_edge_br", br, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h54, 1'b0, 4'd5, 1'b0, 1'b0);
        #1;
        check("post_rst_pred", 32'(pred), 32'd0);
        drive(32'h54, 1'b1, 4'd5, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("first_upd_pred", 32'(pred), 32'd1);
        check("first_upd_br", br, 32'd1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] p;
            logic        u, pr, r;
            logic [3:0]  i;
            int          ei;
            p  = $urandom;
            u  = ($urandom_range(0, 3) != 0);
            i  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            ei = model_idx(p);
            pr = ($urandom_range(0, 1) != 0) ? (ctr_m[i] >= 2) : 1'($urandom);
            r  = 1'($urandom);
            @(negedge clk);
            drive(p, u, i, pr, r);
            #1;
            check("rnd_idx", 32'(lidx), 32'(ei));
            check("rnd_pred", 32'(pred), 32'(ctr_m[ei] >= 2));
            @(posedge clk);
            model_update(u, i, pr, r);
            #1;
            check("rnd_br", br, 32'(br_m));
            check("rnd_mp", mp, 32'(mp_m));
            check("rnd_br_s", 32'(br_s), sat3(br_m));
            check("rnd_mp_s", 32'(mp_s), sat3(mp_m));
        end

        // History check: two taken updates then look up PC 0.
        do_reset();
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            drive(32'h0, 1'b1, 4'd0, 1'b1, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        drive(32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
`ifdef BHT_GSHARE_EN
        check("ghr_idx", 32'(lidx), 32'd3);
`else
        check("ghr_idx", 32'(lidx), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised successor to the single-counter branch predictor in the 5-stage pipeline.
- Holds a PC-indexed table of ENTRIES saturating counters, each CTR_W bits wide.
- IF looks up a prediction combinationally. EX later writes the resolved outcome back to the same table index, which has travelled down the pipeline.
- Also keeps branch and mispredict statistics counters for the testbench and performance reporting.

Parameters:
ENTRIES, 16, number of table entries; power of 2, minimum 2; IDX_W = log2(ENTRIES)
CTR_W, 2, counter width in bits; minimum 1
INIT_CTR, 1, reset value of every counter; must be less than 2^CTR_W; default is weakly not-taken
PC_W, 32, program counter width; must be at least IDX_W+2
STAT_W, 32, width of each statistics counter

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  reset; asynchronous, active-high
lookup_pc_i  input  PC_W  IF-stage PC
predict_o  output  1  prediction: 1 = taken; combinational from lookup_pc_i
lookup_idx_o  output  IDX_W  table index used for this lookup; carried through IF/ID and ID/EX
update_i  input  1  a branch resolved in EX this cycle
update_idx_i  input  IDX_W  index returned from lookup_idx_o for this branch
update_pred_i  input  1  prediction that was made for this branch
result_i  input  1  actual outcome: 1 = taken
stat_branches_o  output  STAT_W  number of resolved branches
stat_mispred_o  output  STAT_W  number of mispredicted branches

Behaviour:
- Index computation:
  - base index = lookup_pc_i[IDX_W+1:2]; PC bits [1:0] are ignored.
  - lookup_idx_o = base index (this changes when the optional feature is enabled; see below).
- Prediction:
  - predict_o = MSB of ctr[lookup_idx_o].
  - Purely combinational; zero latency.
  - No bypass from a same-cycle update.
- Update, on the rising edge when update_i = 1:
  - result_i = 1: ctr[update_idx_i] increments, saturating at 2^CTR_W-1.
  - result_i = 0: ctr[update_idx_i] decrements, saturating at 0.
  - All other entries hold.
  - When update_i = 0, the table holds.
- Same-cycle lookup and update to the same index: predict_o shows the old counter value during that cycle and the new value from the next cycle.
- Statistics:
  - stat_branches_o increments on every update_i.
  - stat_mispred_o increments when update_i = 1 and update_pred_i != result_i.
  - Both counters saturate at all-ones and never wrap.
- Reset:
  - Assertion of rst_i immediately, without waiting for a clock edge, sets every ctr to INIT_CTR and both stat outputs to 0. Any GHR also clears to 0.
  - Reset asserted mid-operation discards any in-flight update.
  - The first update is accepted on the first rising edge after deassertion.
- Reset value of outputs:
  - predict_o = INIT_CTR[CTR_W-1]; with default parameters this is 0.
  - lookup_idx_o follows lookup_pc_i.
  - Both stat outputs = 0.
- CTR_W = 1 degenerates to a last-outcome predictor: the counter is simply set to result_i.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- When defined:
  - Adds an IDX_W-bit global history register (GHR).
  - lookup_idx_o = base index XOR GHR.
  - On every update_i, the GHR shifts left with result_i entering at bit 0. The shift is non-speculative and happens on the same edge as the counter update.
  - The counter update still uses update_idx_i, not a recomputed index.
- When undefined:
  - There is no GHR and lookup_idx_o = base index.
  - There is no extra state and no change in port list.

Test Plan (defaults ENTRIES=16, CTR_W=2, INIT_CTR=1, unless noted):
1. Reset, then lookup_pc_i=0x0000_0054 -> lookup_idx_o=5, predict_o=0, both stat outputs = 0.
2. Training at idx 5:
   - Three updates with result_i=1 -> ctr 1->2->3->3; predict_o becomes 1 after the first edge.
   - Then two with result_i=0 -> ctr 3->2->1; predict_o is 1 after the first and 0 after the second.
3. Four updates:
   - (update_pred_i, result_i) = (0,1),(0,1),(0,1),(1,1).
   - -> stat_branches_o=4, stat_mispred_o=3.
   - With STAT_W=2, a fifth mispredicted update -> both outputs hold at 3.
4. Same-cycle lookup and update of idx 5 (ctr=1, result_i=1) -> predict_o=0 during that cycle and 1 in the following cycle; idx 6 is unchanged.
5. After training idx 5 to 3, assert rst_i between clock edges -> predict_o=0 and both stat outputs = 0 before the next edge.
   - An update presented on the edge during reset has no effect.
6. With BHT_GSHARE_EN: after reset, updates with result_i=1, then 1 -> GHR=0b0011; lookup_pc_i=0x0 -> lookup_idx_o=3. Without the macro, the same stimulus gives lookup_idx_o=0.
